// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/enable bundle between the arbiter and the drivers of one shared line
interface tristate_bus_arbiter_if #(parameter int N_DRIVERS = 2);
  localparam int OW = N_DRIVERS > 2 ? $clog2(N_DRIVERS) : 1;
  logic [N_DRIVERS-1:0] req;
  logic [N_DRIVERS-1:0] active;
  logic [OW-1:0] owner;
  logic bus_busy;
  logic handoff;
  modport master(input req, output active, owner, bus_busy, handoff);
  modport slave(output req, input active, owner, bus_busy, handoff);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin ownership of a shared tristate line with dead cycles between owners
module tristate_bus_arbiter #(
  parameter int N_DRIVERS = 2,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  tristate_bus_arbiter_if.master bus
);
  localparam int OW = N_DRIVERS > 2 ? $clog2(N_DRIVERS) : 1;
  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [N_DRIVERS-1:0] ONE = {{(N_DRIVERS-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state, state_n;
  logic [OW-1:0] rr_ptr, rr_n, owner, owner_n, pick;
  logic [7:0] hold_cnt, hold_n;
  logic [2:0] turn_cnt, turn_n;
  logic [N_DRIVERS-1:0] active, active_n;
  logic handoff, handoff_n, busy, release_own, may_grant;
  always_comb begin
    pick = rr_ptr;
    for (int i = N_DRIVERS; i >= 1; i--)
      if (bus.req[OW'((int'(rr_ptr) + i) % N_DRIVERS)]) pick = OW'((int'(rr_ptr) + i) % N_DRIVERS);
  end
  // in OWN, active is exactly the owner's one-hot, so req & ~active is the set of waiters
  assign release_own = !bus.req[owner] || (hold_cnt >= HOLD_LAST && |(bus.req & ~active));
  assign may_grant = state == IDLE || (state == TURN && turn_cnt == TURN_LAST);
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    owner_n = owner;
    active_n = active;
    hold_n = hold_cnt;
    turn_n = turn_cnt;
    handoff_n = 1'b0;
    if (state == OWN) begin
      hold_n = hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 8'd1;
      if (release_own) begin
        state_n = TURN;
        active_n = '0;
        owner_n = '0;
        turn_n = '0;
      end
    end else if (may_grant) begin
      state_n = |bus.req ? OWN : IDLE;
      if (|bus.req) begin
        owner_n = pick;
        rr_n = pick;
        active_n = ONE << pick;
        hold_n = '0;
        handoff_n = 1'b1;
      end
    end else begin
      turn_n = turn_cnt + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= OW'(N_DRIVERS - 1);
      owner <= '0;
      active <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      handoff <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      owner <= owner_n;
      active <= active_n;
      hold_cnt <= hold_n;
      turn_cnt <= turn_n;
      handoff <= handoff_n;
      busy <= |active_n;
    end
  end
  assign bus.active = active;
  assign bus.owner = owner;
  assign bus.bus_busy = busy;
  assign bus.handoff = handoff;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: three arbiter configurations checked against an ownership-level model every cycle
module tb_tristate_bus_arbiter;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  bit chk_on;
  int n_checks, n_fail;
  tristate_bus_arbiter_if #(.N_DRIVERS(2)) ia();
  tristate_bus_arbiter_if #(.N_DRIVERS(2)) ib();
  tristate_bus_arbiter_if #(.N_DRIVERS(4)) ic();
  tristate_bus_arbiter #(.N_DRIVERS(2), .TURNAROUND(1), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  tristate_bus_arbiter #(.N_DRIVERS(2), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
  tristate_bus_arbiter #(.N_DRIVERS(4), .TURNAROUND(2), .MAX_HOLD(3)) dut_c (.clk(clk), .rst(rst_c), .bus(ic));
  always #5 clk = ~clk;
  // model: current owner (-1 none), cycles owned so far, dead cycles elapsed, last granted driver
  int m_own[3] = '{-1, -1, -1};
  int m_last[3], m_held[3], m_gap[3];
  bit m_ingap[3], m_hand[3];
  int wait_c[4];
  logic [3:0] prev_c;
  int zrun;
  bit seen_nz;
  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step(int k, int n, int t, int h, logic [7:0] r, logic rs);
    bit grant_ok;
    if (rs) begin
      m_own[k] = -1; m_last[k] = n - 1; m_held[k] = 0; m_gap[k] = 0; m_ingap[k] = 0; m_hand[k] = 0;
      return;
    end
    m_hand[k] = 0;
    grant_ok = 0;
    if (m_own[k] >= 0) begin
      m_held[k]++;
      if (!r[m_own[k]] || (m_held[k] >= h && (r & ~(8'd1 << m_own[k])) != 0)) begin
        m_own[k] = -1; m_ingap[k] = 1; m_gap[k] = 0;
      end
    end else if (m_ingap[k]) begin
      m_gap[k]++;
      if (m_gap[k] >= t) begin m_ingap[k] = 0; grant_ok = 1; end
    end else grant_ok = 1;
    if (grant_ok)
      for (int i = 1; i <= n; i++) begin
        int c;
        c = (m_last[k] + i) % n;
        if (r[c[2:0]]) begin
          m_own[k] = c; m_last[k] = c; m_held[k] = 0; m_hand[k] = 1;
          break;
        end
      end
  endtask
  task automatic cmp(int k, string tag, logic [7:0] act, int own, logic busy, logic hand);
    chk({tag, "_active"}, int'(act), m_own[k] < 0 ? 0 : int'(8'd1 << m_own[k]));
    chk({tag, "_owner"}, own, m_own[k] < 0 ? 0 : m_own[k]);
    chk({tag, "_busy"}, int'(busy), int'(m_own[k] >= 0));
    chk({tag, "_handoff"}, int'(hand), int'(m_hand[k]));
  endtask
  always @(posedge clk) begin
    step(0, 2, 1, 4, {6'b0, ia.req}, rst_a);
    step(1, 2, 3, 4, {6'b0, ib.req}, rst_b);
    step(2, 4, 2, 3, {4'b0, ic.req}, rst_c);
    for (int i = 0; i < 4; i++) wait_c[i] = (!rst_c && ic.req[i] && !ic.active[i]) ? wait_c[i] + 1 : 0;
  end
  always @(negedge clk) if (chk_on) begin
    int n_en, line;
    cmp(0, "a", {6'b0, ia.active}, int'(ia.owner), ia.bus_busy, ia.handoff);
    cmp(1, "b", {6'b0, ib.active}, int'(ib.owner), ib.bus_busy, ib.handoff);
    cmp(2, "c", {4'b0, ic.active}, int'(ic.owner), ic.bus_busy, ic.handoff);
    n_en = 0;
    line = 0;
    for (int i = 0; i < 4; i++) if (ic.active[i]) begin n_en++; line = i + 1; end
    chk("c_onehot", int'($countones(ic.active) <= 1), 1);
    chk("c_line_contention", int'(n_en > 1), 0);
    if (ic.bus_busy) chk("c_line_value", line, int'(ic.owner) + 1);
    if (ic.active != 0 && ic.active != prev_c && seen_nz) chk("c_turnaround", int'(zrun >= 2), 1);
    for (int i = 0; i < 4; i++) chk("c_starvation", int'(wait_c[i] <= 20), 1);
    zrun = ic.active == 0 ? zrun + 1 : 0;
    seen_nz = !rst_c && (seen_nz || ic.active != 0);
    prev_c = ic.active;
  end
  initial begin
    int seq3[14] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1};
    ia.req = '0; ib.req = '0; ic.req = '0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    @(negedge clk);
    chk_on = 1;
    fork
      begin
        ia.req = 2'b11;
        repeat (2) begin
          @(negedge clk);
          chk("t1_rst_active", int'(ia.active), 0);
          chk("t1_rst_handoff", int'(ia.handoff), 0);
        end
        rst_a = 0; ia.req = 2'b01;
        @(negedge clk);
        chk("t1_grant", int'(ia.active), 1);
        chk("t1_handoff", int'(ia.handoff), 1);
        repeat (9) @(negedge clk);
        chk("t2_hold", int'(ia.active), 1);
        chk("t2_handoff_low", int'(ia.handoff), 0);
        ia.req = 2'b00;
        @(negedge clk);
        chk("t2_release", int'(ia.active), 0);
        @(negedge clk);
        rst_a = 1;
        @(negedge clk);
        rst_a = 0; ia.req = 2'b11;
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          chk($sformatf("t3_seq%0d", i), int'(ia.active), seq3[i]);
        end
        @(negedge clk);
        chk("t5_gap", int'(ia.active), 0);
        @(negedge clk);
        chk("t5_own1", int'(ia.active), 2);
        rst_a = 1;
        @(negedge clk);
        chk("t5_rst_drop", int'(ia.active), 0);
        rst_a = 0;
        @(negedge clk);
        chk("t5_first0", int'(ia.active), 1);
        rst_a = 1; rst_b = 1; ia.req = 0; ib.req = 0;
        @(negedge clk);
        rst_a = 0; rst_b = 0; ia.req = 2'b11; ib.req = 2'b11;
        @(negedge clk);
        chk("t4_a_own0", int'(ia.active), 1);
        chk("t4_b_own0", int'(ib.active), 1);
        @(negedge clk);
        chk("t4_a_own0b", int'(ia.active), 1);
        ia.req = 2'b10; ib.req = 2'b10;
        @(negedge clk);
        chk("t4_a_gap", int'(ia.active), 0);
        chk("t4_b_gap1", int'(ib.active), 0);
        @(negedge clk);
        chk("t4_a_own1", int'(ia.active), 2);
        chk("t4_b_gap2", int'(ib.active), 0);
        @(negedge clk);
        chk("t4_b_gap3", int'(ib.active), 0);
        @(negedge clk);
        chk("t4_b_own1", int'(ib.active), 2);
        repeat (3) @(negedge clk);
      end
      begin
        repeat (2) @(negedge clk);
        rst_c = 0;
        for (int i = 0; i < 5000; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) ic.req = 4'($urandom_range(0, 15));
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Arbitrates ownership of a single shared tristate signal (sig_out) among N_DRIVERS registered drivers.
- Each driver has its own drive-enable ("active") input; this block generates those enables.
- Guarantees at most one enable high at any time, and inserts TURNAROUND dead cycles between owners so drivers never contend.
- Round-robin fairness, with a bounded hold time whenever another driver is waiting.

Parameters:
- N_DRIVERS, 2: number of drivers sharing the bus; range 2..8.
- TURNAROUND, 1: cycles with all enables low between two different ownerships; range 1..7.
- MAX_HOLD, 8: maximum consecutive owned cycles while any other req is pending; range 1..255.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_DRIVERS  level request per driver; held high while the driver wants the bus.
- active  output  N_DRIVERS  registered one-hot-or-zero drive enables, wired to the drivers' active inputs.
- owner  output  max(1,$clog2(N_DRIVERS))  index of the current owner; valid only when bus_busy=1, else 0.
- bus_busy  output  1  high when any active bit is high.
- handoff  output  1  one-cycle pulse in the first cycle a new ownership begins.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On a rst edge:
  - active=0, owner=0, bus_busy=0, handoff=0.
  - State=IDLE, rr_ptr=N_DRIVERS-1 (driver 0 has first priority), hold_cnt=0, turn_cnt=0.
  - rst dominates every other condition, including mid-ownership: enables drop at that same edge, with no turnaround.
- All outputs are registered; no combinational path from req to active.
- States: IDLE, OWN, TURN.
- Arbitration function pick(req, rr_ptr): the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_DRIVERS.
- IDLE:
  - If req≠0 at an edge: owner=pick, that bit of active is set, handoff=1 for the next cycle.
  - Also at that edge: rr_ptr=owner, hold_cnt=0, state goes to OWN.
  - Latency is 1 cycle: req sampled high at edge k gives active high from edge k onward, visible in cycle k+1.
- OWN, evaluated each edge:
  - hold_cnt increments and saturates at MAX_HOLD.
  - Release if req[owner]=0, or if hold_cnt+1 >= MAX_HOLD and (req & ~onehot(owner)) ≠ 0.
  - On release: active=0 and turn_cnt=0 at that edge, state goes to TURN.
  - A sole requester is never forced off; it holds indefinitely.
- TURN:
  - active stays 0 for exactly TURNAROUND cycles.
  - At the edge where turn_cnt==TURNAROUND-1: if req≠0, grant pick(req, rr_ptr) directly (as in IDLE), else go to IDLE.
  - Otherwise turn_cnt increments.
  - The previous owner may be re-granted if it is the only requester; it still waits out the turnaround.
- Simultaneous events:
  - The owner dropping req on the same edge a hold expiry would occur counts as an ordinary release.
  - A new req arriving in TURN is considered at the final TURN edge.
- Invariants:
  - popcount(active) ≤ 1 at all times.
  - Any change of active from one nonzero value to a different one is separated by ≥ TURNAROUND all-zero cycles.
  - A continuously requesting driver is granted within N_DRIVERS*(MAX_HOLD+TURNAROUND) cycles.
- Outputs:
  - bus_busy = |active, registered alongside active.
  - handoff is high only in the first cycle of each ownership, including a re-grant to the same driver.

Test Plan:
1. Reset: rst high 2 cycles with req=11 -> active=00, owner=0, handoff=0 throughout. Then rst low, req=01 -> active=01 from the next cycle, with handoff=1 for that one cycle.
2. Single requester (N=2, TURNAROUND=1, MAX_HOLD=4): req=01 for 10 cycles then 00 -> active=01 for 10 cycles, never forced off. active goes to 00 one cycle after req falls.
3. Contention: req=11 held continuously -> active sequence 01 ×4, 00 ×1, 10 ×4, 00 ×1, 01 ×4… The owner field alternates 0, 1, 0.
4. Early release with a waiter: req=11, then req[0] drops after 2 owned cycles -> active=01 ×2, 00 ×1, 10. Repeat with TURNAROUND=3 -> exactly 3 zero cycles.
5. Reset mid-ownership: while active=10, assert rst for 1 cycle -> active=00 at that edge. After release with req=11, driver 0 is granted first.
6. Random req for 5000 cycles with N=4, TURNAROUND=2, MAX_HOLD=3. Assert all three invariants on every cycle, and model the shared line to check it never sees two enabled drivers.
